// File: rtl/bf16_acc_stage.sv
// bf16_acc_stage: sequential bf16 accumulator (align/add/normalise/round, RNE, FTZ)
// that emits one sum per in_last-terminated group over valid/ready handshakes.
module bf16_acc_stage #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);
   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
   state_t state;
   logic [15:0] op, acc, sv;
   logic [CNT_W-1:0] count;
   logic last, ovf, sg, sub, zs, z, sp;
   logic [9:0] e;
   logic [11:0] m;
   logic [10:0] sm;
   logic [7:0] ea, eb, ma, mb, e_big, e_sm, m_big, m_sm, d;
   logic a_nan, b_nan, a_inf, b_inf, swap;
   logic [21:0] sh;
   logic [10:0] al;
   logic [3:0] lz;
   logic [9:0] en, er;
   logic [8:0] r9;
   logic up, inf;
   logic [15:0] res;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign out_data  = acc;
   assign out_count = count;
   assign out_ovf   = ovf;
   // exp==0 operands are treated as signed zero with no mantissa
   assign ea    = acc[14:7];
   assign eb    = op[14:7];
   assign ma    = ea != 8'd0 ? {1'b1, acc[6:0]} : 8'd0;
   assign mb    = eb != 8'd0 ? {1'b1, op[6:0]} : 8'd0;
   assign a_nan = &ea && |acc[6:0];
   assign b_nan = &eb && |op[6:0];
   assign a_inf = &ea && ~|acc[6:0];
   assign b_inf = &eb && ~|op[6:0];
   assign swap  = {eb, mb} > {ea, ma};
   assign e_big = swap ? eb : ea;
   assign e_sm  = swap ? ea : eb;
   assign m_big = swap ? mb : ma;
   assign m_sm  = swap ? ma : mb;
   assign d     = e_big - e_sm;
   assign sh    = {m_sm, 14'd0} >> d;
   assign al    = d >= 8'd11 ? {10'd0, |m_sm} : {sh[21:12], sh[11] | (|sh[10:0])};
   always_comb begin
      lz = 4'd11;
      for (int i = 0; i < 11; i++) if (m[i]) lz = 4'(10 - i);
   end
   assign en  = e - {6'd0, lz};
   assign up  = m[2] & (m[1] | m[0] | m[3]);
   assign r9  = {1'b0, m[10:3]} + {8'd0, up};
   assign er  = e + {9'd0, r9[8]};
   assign inf = er >= 10'd255;
   assign res = sp ? sv : z ? {sg, 15'd0} : inf ? {sg, 8'hFF, 7'd0} : {sg, er[7:0], r9[6:0]};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         ovf   <= 1'b0;
         op    <= '0;
         last  <= 1'b0;
         sg    <= 1'b0;
         sub   <= 1'b0;
         zs    <= 1'b0;
         z     <= 1'b0;
         sp    <= 1'b0;
         sv    <= '0;
         e     <= '0;
         m     <= '0;
         sm    <= '0;
      end else
         case (state)
            IDLE: if (in_valid) begin
               op    <= in_data;
               last  <= in_last;
               count <= count != '1 ? count + 1'b1 : count;
               state <= ALIGN;
            end
            ALIGN: begin
               sg    <= swap ? op[15] : acc[15];
               sub   <= op[15] ^ acc[15];
               zs    <= op[15] & acc[15];
               z     <= 1'b0;
               sp    <= a_nan | b_nan | a_inf | b_inf;
               sv    <= (a_nan | b_nan | (a_inf & b_inf & (acc[15] ^ op[15]))) ? 16'h7FC0 : a_inf ? acc : op;
               e     <= {2'd0, e_big};
               m     <= {1'b0, m_big, 3'd0};
               sm    <= al;
               state <= ADD;
            end
            ADD: begin
               m     <= sub ? m - {1'b0, sm} : m + {1'b0, sm};
               state <= NORM;
            end
            NORM: begin
               // a true zero takes the joint sign; an underflow flush keeps the result sign
               if (m[11]) begin
                  m <= {1'b0, m[11:2], m[1] | m[0]};
                  e <= e + 10'd1;
               end else if (m == 12'd0) begin
                  z  <= 1'b1;
                  sg <= zs;
               end else begin
                  m <= m << lz;
                  e <= en;
                  z <= en[9] | (en == 10'd0);
               end
               state <= ROUND;
            end
            ROUND: begin
               acc   <= res;
               ovf   <= ovf | (~sp & ~z & inf);
               state <= last ? DONE : IDLE;
            end
            DONE: if (out_ready) begin
               acc   <= '0;
               count <= '0;
               ovf   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_bf16_acc_stage.sv
// tb_bf16_acc_stage: directed checks of the bf16 accumulation stage against
// hand-computed group sums, handshake holds and reset behaviour.
module tb_bf16_acc_stage;
   logic clk = 1'b0;
   logic rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
   logic [15:0] in_data, out_data;
   logic [7:0] out_count;
   int n_cmp = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   bf16_acc_stage #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
      .out_ovf(out_ovf)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [15:0] d, input logic l);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'h0;
      in_last  = 1'b0;
   endtask
   task automatic get(input string tag, input logic [15:0] d, input logic [7:0] c, input logic o);
      int t = 0;
      @(negedge clk);
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_data"}, {16'd0, out_data}, {16'd0, d});
      chk({tag, "_count"}, {24'd0, out_count}, {24'd0, c});
      chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, o});
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask
   typedef struct {logic [15:0] a; logic [15:0] b; logic [15:0] c; int n; logic [15:0] s; logic o;} grp_t;
   grp_t grps[6] = '{
      '{16'h4000, 16'h3F80, 16'hBF80, 3, 16'h4000, 1'b0},
      '{16'h4080, 16'hC0A0, 16'h0000, 2, 16'hBF80, 1'b0},
      '{16'h0001, 16'h3F80, 16'h0000, 2, 16'h3F80, 1'b0},
      '{16'h7FC0, 16'h3F80, 16'h0000, 2, 16'h7FC0, 1'b0},
      '{16'h7F80, 16'h3F80, 16'h0000, 2, 16'h7F80, 1'b0},
      '{16'h0100, 16'h80C0, 16'h0000, 2, 16'h0000, 1'b0}
   };
   initial begin
      logic [15:0] held;
      int t;
      rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, out_data}, 32'd0);
      rst_n = 1'b1;
      // basic sum, in_ready low while computing
      send(16'h3F80, 1'b0);
      chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
      send(16'h3F80, 1'b0);
      send(16'h4000, 1'b1);
      get("sum4", 16'h4080, 8'd3, 1'b0);
      send(16'h3FC0, 1'b0); send(16'hC000, 1'b1);
      get("neg_half", 16'hBF00, 8'd2, 1'b0);
      send(16'h4000, 1'b0); send(16'hC000, 1'b1);
      get("cancel", 16'h0000, 8'd2, 1'b0);
      send(16'h3F80, 1'b0); send(16'h3B80, 1'b1);
      get("tie_even", 16'h3F80, 8'd2, 1'b0);
      send(16'h3F81, 1'b0); send(16'h3B80, 1'b1);
      get("tie_up", 16'h3F82, 8'd2, 1'b0);
      send(16'h7F7F, 1'b0); send(16'h7F7F, 1'b1);
      get("ovf", 16'h7F80, 8'd2, 1'b1);
      send(16'h7F80, 1'b0); send(16'hFF80, 1'b1);
      get("inf_nan", 16'h7FC0, 8'd2, 1'b0);
      // hold the result with out_ready low
      send(16'h4040, 1'b1);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      held = out_data;
      chk("hold_first", {16'd0, held}, 32'h4040);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_data", {16'd0, out_data}, {16'd0, held});
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      get("hold_end", 16'h4040, 8'd1, 1'b0);
      // back-to-back groups with random gaps
      foreach (grps[g]) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(grps[g].a, grps[g].n == 1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(grps[g].b, grps[g].n == 2);
         if (grps[g].n == 3) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(grps[g].c, 1'b1);
         end
         get($sformatf("grp%0d", g), grps[g].s, 8'(grps[g].n), grps[g].o);
      end
      // count saturation
      for (int i = 0; i < 300; i++) send(16'h0000, i == 299);
      get("sat", 16'h0000, 8'd255, 1'b0);
      // reset mid-ALIGN
      send(16'h3F80, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("amid_in_ready", {31'd0, in_ready}, 32'd1);
      chk("amid_count", {24'd0, out_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("arel_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arel_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arel_out_data", {16'd0, out_data}, 32'd0);
      chk("arel_count", {24'd0, out_count}, 32'd0);
      repeat (10) @(negedge clk);
      chk("arel_no_out", {31'd0, out_valid}, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
